// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_WAIT
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IMEM,
        OWN_DMEM
    } arb_owner_e;

    localparam int unsigned ARB_STARVE_LIMIT = 4;
    localparam logic [3:0]  ARB_BE_FULL      = 4'hF;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating counter of consecutive dmem grants taken while imem was waiting.
module arb_starve_counter #(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);

    localparam int unsigned W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt_q;

    assign sat_o = (cnt_q == W'(LIMIT));

    // Clear wins over increment so an imem grant always restarts the count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && !sat_o) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requests onto one shared memory port, one
// outstanding transaction at a time, with bounded imem starvation.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = ARB_STARVE_LIMIT
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        imem_req_i,
    input  logic [31:0] imem_addr_i,
    output logic        imem_gnt_o,
    output logic        imem_rvalid_o,
    output logic [31:0] imem_rdata_o,

    input  logic        dmem_req_i,
    input  logic        dmem_we_i,
    input  logic [3:0]  dmem_be_i,
    input  logic [31:0] dmem_addr_i,
    input  logic [31:0] dmem_wdata_i,
    output logic        dmem_gnt_o,
    output logic        dmem_rvalid_o,
    output logic [31:0] dmem_rdata_o,

    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,

    output logic        imem_stall_o,
    output logic        dmem_stall_o
);

    arb_state_e state_q, state_d;
    arb_owner_e owner_q, owner_d;

    logic starve_sat;
    logic sel_imem;
    logic sel_dmem;
    logic cnt_inc;
    logic cnt_clr;

    // dmem has priority unless imem has been passed over STARVE_LIMIT times.
    assign sel_imem = imem_req_i & (~dmem_req_i | starve_sat);
    assign sel_dmem = dmem_req_i & ~sel_imem;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ARB_IDLE;
            owner_q <= OWN_NONE;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    // Outputs are gated by rst_ni so nothing leaks onto the bus during reset.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        bus_req_o     = 1'b0;
        bus_we_o      = 1'b0;
        bus_be_o      = '0;
        bus_addr_o    = '0;
        bus_wdata_o   = '0;
        imem_gnt_o    = 1'b0;
        dmem_gnt_o    = 1'b0;
        imem_rvalid_o = 1'b0;
        dmem_rvalid_o = 1'b0;
        imem_rdata_o  = '0;
        dmem_rdata_o  = '0;

        if (rst_ni) begin
            unique case (state_q)
                ARB_IDLE: begin
                    bus_req_o = imem_req_i | dmem_req_i;
                    if (sel_imem) begin
                        bus_be_o   = ARB_BE_FULL;
                        bus_addr_o = imem_addr_i;
                        imem_gnt_o = bus_gnt_i;
                    end else if (sel_dmem) begin
                        bus_we_o    = dmem_we_i;
                        bus_be_o    = dmem_be_i;
                        bus_addr_o  = dmem_addr_i;
                        bus_wdata_o = dmem_wdata_i;
                        dmem_gnt_o  = bus_gnt_i;
                    end
                    if (bus_req_o && bus_gnt_i) begin
                        state_d = ARB_WAIT;
                        owner_d = sel_imem ? OWN_IMEM : OWN_DMEM;
                    end
                end
                ARB_WAIT: begin
                    if (bus_rvalid_i) begin
                        unique case (owner_q)
                            OWN_IMEM: begin
                                imem_rvalid_o = 1'b1;
                                imem_rdata_o  = bus_rdata_i;
                            end
                            OWN_DMEM: begin
                                dmem_rvalid_o = 1'b1;
                                dmem_rdata_o  = bus_rdata_i;
                            end
                            default: ;
                        endcase
                        state_d = ARB_IDLE;
                        owner_d = OWN_NONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cnt_inc = dmem_gnt_o & imem_req_i;
    assign cnt_clr = imem_gnt_o | ((state_q == ARB_IDLE) & ~imem_req_i);

    arb_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (cnt_inc),
        .clr_i  (cnt_clr),
        .sat_o  (starve_sat)
    );

    assign imem_stall_o = (imem_req_i | (owner_q == OWN_IMEM)) & ~imem_rvalid_o;
    assign dmem_stall_o = (dmem_req_i | (owner_q == OWN_DMEM)) & ~dmem_rvalid_o;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed-vector bench for mem_port_arbiter, built with STARVE_LIMIT = 2.
module tb_mem_port_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        imem_req_i;
    logic [31:0] imem_addr_i;
    logic        imem_gnt_o, imem_rvalid_o;
    logic [31:0] imem_rdata_o;
    logic        dmem_req_i, dmem_we_i;
    logic [3:0]  dmem_be_i;
    logic [31:0] dmem_addr_i, dmem_wdata_i;
    logic        dmem_gnt_o, dmem_rvalid_o;
    logic [31:0] dmem_rdata_o;
    logic        bus_req_o, bus_we_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic        bus_gnt_i, bus_rvalid_i;
    logic [31:0] bus_rdata_i;
    logic        imem_stall_o, dmem_stall_o;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk_i = ~clk_i;

    mem_port_arbiter #(
        .STARVE_LIMIT (2)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .imem_req_i    (imem_req_i),
        .imem_addr_i   (imem_addr_i),
        .imem_gnt_o    (imem_gnt_o),
        .imem_rvalid_o (imem_rvalid_o),
        .imem_rdata_o  (imem_rdata_o),
        .dmem_req_i    (dmem_req_i),
        .dmem_we_i     (dmem_we_i),
        .dmem_be_i     (dmem_be_i),
        .dmem_addr_i   (dmem_addr_i),
        .dmem_wdata_i  (dmem_wdata_i),
        .dmem_gnt_o    (dmem_gnt_o),
        .dmem_rvalid_o (dmem_rvalid_o),
        .dmem_rdata_o  (dmem_rdata_o),
        .bus_req_o     (bus_req_o),
        .bus_we_o      (bus_we_o),
        .bus_be_o      (bus_be_o),
        .bus_addr_o    (bus_addr_o),
        .bus_wdata_o   (bus_wdata_o),
        .bus_gnt_i     (bus_gnt_i),
        .bus_rvalid_i  (bus_rvalid_i),
        .bus_rdata_i   (bus_rdata_i),
        .imem_stall_o  (imem_stall_o),
        .dmem_stall_o  (dmem_stall_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    task automatic quiet();
        imem_req_i   = 1'b0;
        imem_addr_i  = '0;
        dmem_req_i   = 1'b0;
        dmem_we_i    = 1'b0;
        dmem_be_i    = '0;
        dmem_addr_i  = '0;
        dmem_wdata_i = '0;
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b0;
        bus_rdata_i  = '0;
    endtask

    logic [5:0] order;

    initial begin
        quiet();
        rst_ni     = 1'b0;
        imem_req_i = 1'b1;
        bus_gnt_i  = 1'b1;

        // Reset: bus quiet, stall follows request.
        sample();
        chk("rst_bus_req", bus_req_o, 1'b0);
        chk("rst_imem_gnt", imem_gnt_o, 1'b0);
        chk("rst_imem_stall", imem_stall_o, 1'b1);
        chk("rst_dmem_stall", dmem_stall_o, 1'b0);
        next_cycle();
        quiet();
        rst_ni = 1'b1;
        next_cycle();

        // imem-only read, rvalid two cycles after grant.
        imem_req_i   = 1'b1;
        imem_addr_i  = 32'h0000_0100;
        dmem_wdata_i = 32'hFFFF_0000;
        dmem_we_i    = 1'b1;
        bus_gnt_i    = 1'b1;
        sample();
        chk("a_imem_gnt", imem_gnt_o, 1'b1);
        chk("a_dmem_gnt", dmem_gnt_o, 1'b0);
        chk("a_bus_req", bus_req_o, 1'b1);
        chk("a_bus_addr", bus_addr_o, 32'h0000_0100);
        chk("a_bus_we", bus_we_o, 1'b0);
        chk("a_bus_be", bus_be_o, 4'hF);
        chk("a_bus_wdata", bus_wdata_o, 32'h0);
        chk("a_stall0", imem_stall_o, 1'b1);
        next_cycle();
        imem_req_i = 1'b0;
        sample();
        chk("a_wait_req", bus_req_o, 1'b0);
        chk("a_wait_gnt", imem_gnt_o, 1'b0);
        chk("a_stall1", imem_stall_o, 1'b1);
        chk("a_early_rv", imem_rvalid_o, 1'b0);
        next_cycle();
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'hDEAD_BEEF;
        sample();
        chk("a_rvalid", imem_rvalid_o, 1'b1);
        chk("a_rdata", imem_rdata_o, 32'hDEAD_BEEF);
        chk("a_d_rvalid", dmem_rvalid_o, 1'b0);
        chk("a_stall2", imem_stall_o, 1'b0);
        next_cycle();
        quiet();
        sample();
        chk("a_idle_req", bus_req_o, 1'b0);
        chk("a_idle_rv", imem_rvalid_o, 1'b0);
        next_cycle();

        // Simultaneous requests: dmem first with write fields passed through.
        imem_req_i   = 1'b1;
        imem_addr_i  = 32'h0000_0104;
        dmem_req_i   = 1'b1;
        dmem_we_i    = 1'b1;
        dmem_be_i    = 4'h5;
        dmem_addr_i  = 32'h0000_2000;
        dmem_wdata_i = 32'h1234_5678;
        bus_gnt_i    = 1'b1;
        sample();
        chk("b_dmem_gnt", dmem_gnt_o, 1'b1);
        chk("b_imem_gnt", imem_gnt_o, 1'b0);
        chk("b_bus_we", bus_we_o, 1'b1);
        chk("b_bus_be", bus_be_o, 4'h5);
        chk("b_bus_addr", bus_addr_o, 32'h0000_2000);
        chk("b_bus_wdata", bus_wdata_o, 32'h1234_5678);
        chk("b_istall", imem_stall_o, 1'b1);
        chk("b_dstall", dmem_stall_o, 1'b1);
        next_cycle();
        dmem_req_i   = 1'b0;
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'hAAAA_5555;
        sample();
        chk("b_d_rvalid", dmem_rvalid_o, 1'b1);
        chk("b_d_rdata", dmem_rdata_o, 32'hAAAA_5555);
        chk("b_i_rvalid", imem_rvalid_o, 1'b0);
        chk("b_wait_req", bus_req_o, 1'b0);
        chk("b_wait_igt", imem_gnt_o, 1'b0);
        chk("b_dstall_rv", dmem_stall_o, 1'b0);
        next_cycle();
        bus_rvalid_i = 1'b0;
        sample();
        chk("b_imem_gnt2", imem_gnt_o, 1'b1);
        chk("b_addr2", bus_addr_o, 32'h0000_0104);
        chk("b_we2", bus_we_o, 1'b0);
        chk("b_be2", bus_be_o, 4'hF);
        chk("b_wdata2", bus_wdata_o, 32'h0);
        next_cycle();
        // New dmem request in the rvalid cycle must wait for IDLE.
        imem_req_i   = 1'b0;
        dmem_req_i   = 1'b1;
        dmem_we_i    = 1'b0;
        dmem_be_i    = 4'hF;
        dmem_addr_i  = 32'h0000_3000;
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'h1111_2222;
        sample();
        chk("b_i_rvalid2", imem_rvalid_o, 1'b1);
        chk("b_i_rdata2", imem_rdata_o, 32'h1111_2222);
        chk("b_same_req", bus_req_o, 1'b0);
        chk("b_same_gnt", dmem_gnt_o, 1'b0);
        next_cycle();
        bus_rvalid_i = 1'b0;
        sample();
        chk("b_late_gnt", dmem_gnt_o, 1'b1);
        chk("b_late_addr", bus_addr_o, 32'h0000_3000);
        next_cycle();
        dmem_req_i   = 1'b0;
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'h0000_0005;
        sample();
        chk("b_late_rv", dmem_rvalid_o, 1'b1);
        chk("b_late_rd", dmem_rdata_o, 32'h0000_0005);
        next_cycle();
        quiet();
        next_cycle();

        // Starvation bound of 2 with both requests held.
        order        = 6'b100100;
        imem_req_i   = 1'b1;
        imem_addr_i  = 32'h0000_0108;
        dmem_req_i   = 1'b1;
        dmem_addr_i  = 32'h0000_4000;
        dmem_be_i    = 4'hF;
        bus_gnt_i    = 1'b1;
        bus_rvalid_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus_rdata_i = 32'hC0DE_0000 + 32'(i);
            sample();
            chk("c_igrant", imem_gnt_o, order[i]);
            chk("c_dgrant", dmem_gnt_o, !order[i]);
            chk("c_idle_rv", imem_rvalid_o | dmem_rvalid_o, 1'b0);
            next_cycle();
            sample();
            chk("c_irvalid", imem_rvalid_o, order[i]);
            chk("c_drvalid", dmem_rvalid_o, !order[i]);
            next_cycle();
        end
        quiet();

        // Spurious rvalid in IDLE, then five cycles without bus grant.
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'hBADB_ADBA;
        sample();
        chk("d_spur_irv", imem_rvalid_o, 1'b0);
        chk("d_spur_drv", dmem_rvalid_o, 1'b0);
        chk("d_spur_req", bus_req_o, 1'b0);
        next_cycle();
        imem_req_i  = 1'b1;
        imem_addr_i = 32'h0000_0200;
        for (int i = 0; i < 5; i++) begin
            sample();
            chk("d_hold_req", bus_req_o, 1'b1);
            chk("d_hold_addr", bus_addr_o, 32'h0000_0200);
            chk("d_hold_gnt", imem_gnt_o, 1'b0);
            chk("d_hold_rv", imem_rvalid_o, 1'b0);
            next_cycle();
        end
        bus_gnt_i    = 1'b1;
        bus_rvalid_i = 1'b0;
        sample();
        chk("d_gnt", imem_gnt_o, 1'b1);
        next_cycle();
        imem_req_i   = 1'b0;
        bus_gnt_i    = 1'b0;
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'h0F0F_0F0F;
        sample();
        chk("d_rvalid", imem_rvalid_o, 1'b1);
        chk("d_rdata", imem_rdata_o, 32'h0F0F_0F0F);
        next_cycle();
        quiet();
        next_cycle();

        // Reset mid-WAIT with dmem owner; late rvalid must be dropped.
        imem_req_i  = 1'b1;
        imem_addr_i = 32'h0000_0500;
        dmem_req_i  = 1'b1;
        dmem_addr_i = 32'h0000_0400;
        dmem_be_i   = 4'hF;
        bus_gnt_i   = 1'b1;
        sample();
        chk("e_dgnt0", dmem_gnt_o, 1'b1);
        next_cycle();
        bus_gnt_i = 1'b0;
        sample();
        chk("e_wait_req", bus_req_o, 1'b0);
        chk("e_wait_dst", dmem_stall_o, 1'b1);
        next_cycle();
        rst_ni    = 1'b0;
        bus_gnt_i = 1'b1;
        sample();
        chk("e_rst_req", bus_req_o, 1'b0);
        chk("e_rst_addr", bus_addr_o, 32'h0);
        chk("e_rst_dgnt", dmem_gnt_o, 1'b0);
        chk("e_rst_igst", imem_stall_o, 1'b1);
        chk("e_rst_dst", dmem_stall_o, 1'b1);
        next_cycle();
        rst_ni    = 1'b1;
        bus_gnt_i = 1'b0;
        sample();
        chk("e_rel_req", bus_req_o, 1'b1);
        chk("e_rel_addr", bus_addr_o, 32'h0000_0400);
        next_cycle();
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'hBAD0_BAD0;
        sample();
        chk("e_late_drv", dmem_rvalid_o, 1'b0);
        chk("e_late_drd", dmem_rdata_o, 32'h0);
        chk("e_late_irv", imem_rvalid_o, 1'b0);
        chk("e_late_req", bus_req_o, 1'b1);
        next_cycle();
        order     = 6'b000100;
        bus_gnt_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus_rvalid_i = 1'b0;
            sample();
            chk("e_igrant", imem_gnt_o, order[i]);
            chk("e_dgrant", dmem_gnt_o, !order[i]);
            next_cycle();
            bus_rvalid_i = 1'b1;
            sample();
            chk("e_irvalid", imem_rvalid_o, order[i]);
            chk("e_drvalid", dmem_rvalid_o, !order[i]);
            next_cycle();
        end
        quiet();
        next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, range 1..15: the maximum number of consecutive dmem grants while imem waits.
REQ-002 SHALL have port clk_i, in, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_ni, in, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have imem_req_i (in, 1) and imem_addr_i (in, 32): the fetch request.
REQ-005 SHALL have imem_gnt_o (out, 1), imem_rvalid_o (out, 1) and imem_rdata_o (out, 32): the fetch response.
REQ-006 SHALL have dmem_req_i (in, 1), dmem_we_i (in, 1), dmem_be_i (in, 4), dmem_addr_i (in, 32) and dmem_wdata_i (in, 32): the data request.
REQ-007 SHALL have dmem_gnt_o (out, 1), dmem_rvalid_o (out, 1) and dmem_rdata_o (out, 32): the data response.
REQ-008 SHALL have bus_req_o, bus_we_o, bus_be_o[3:0], bus_addr_o[31:0] and bus_wdata_o[31:0], all out: the shared memory port.
REQ-009 SHALL have bus_gnt_i (in, 1), bus_rvalid_i (in, 1) and bus_rdata_i (in, 32): the shared port response.
REQ-010 SHALL have imem_stall_o and dmem_stall_o (out, 1 each): stall requests to the hazard unit.

Function
REQ-011 SHALL implement FSM states IDLE and WAIT, plus an owner register in {NONE, IMEM, DMEM}.
REQ-012 IDLE behaviour SHALL be:
- bus_req_o = imem_req_i | dmem_req_i.
- bus_addr_o, bus_we_o, bus_be_o and bus_wdata_o SHALL come combinationally from the selected requester.
- imem selected: bus_we_o = 0, bus_be_o = 4'hF, bus_wdata_o = 0.
REQ-013 Selection SHALL be as follows:
- Only one requester active: select it.
- Both active: select dmem, unless the starvation count equals STARVE_LIMIT, in which case select imem.
REQ-014 SHALL drive the grant combinationally in the same cycle: <sel>_gnt_o = bus_gnt_i & selected; the unselected gnt_o SHALL be 0.
REQ-015 On the edge where bus_req_o & bus_gnt_i, SHALL capture owner = selected and move IDLE -> WAIT.
REQ-016 In WAIT, SHALL hold bus_req_o = 0 and both gnt_o = 0, allowing only one outstanding transaction.
REQ-017 In WAIT with bus_rvalid_i, SHALL set <owner>_rvalid_o = 1 and <owner>_rdata_o = bus_rdata_i in the same cycle, then move WAIT -> IDLE with owner = NONE.
REQ-018 Writes SHALL also complete on bus_rvalid_i; the rdata of a write is don't-care.
REQ-019 Response latency SHALL be zero cycles from bus_rvalid_i. The minimum spacing between grants SHALL be 2 cycles (grant, then rvalid in the next cycle, then IDLE).
REQ-020 The starvation counter SHALL:
- increment, saturating at STARVE_LIMIT, on each dmem grant made while imem_req_i = 1;
- clear on an imem grant, or on any cycle with imem_req_i = 0 in IDLE;
- be $clog2(STARVE_LIMIT+1) bits wide.
REQ-021 imem_stall_o SHALL equal (imem_req_i | owner == IMEM) & ~imem_rvalid_o; dmem_stall_o SHALL be defined the same way.
REQ-022 A requester MAY drop its req before grant; nothing is issued and no state changes.
REQ-023 Once granted, the response SHALL always be delivered to the owner, even if that requester was squashed; the owner discards it.
REQ-024 bus_rvalid_i in IDLE SHALL be ignored: no rvalid_o is produced and the state is unchanged.
REQ-025 A new request seen in the same cycle as bus_rvalid_i SHALL NOT be issued until the next cycle (IDLE).

Reset
REQ-026 On rst_ni low, asynchronously and regardless of clock, SHALL set state = IDLE, owner = NONE and starvation count = 0.
REQ-027 While in reset, all *_o SHALL be 0 except *_stall_o, which follow REQ-021 from the requests.
REQ-028 Reset during WAIT SHALL abandon the transaction; a late bus_rvalid_i after reset SHALL fall under REQ-024.

Structure
REQ-029 The shared package SHALL hold the arb_state_e enum {ARB_IDLE, ARB_WAIT}, the arb_owner_e enum {OWN_NONE, OWN_IMEM, OWN_DMEM} and the default STARVE_LIMIT constant.
REQ-030 SHALL contain one sub-module, arb_starve_counter (parameterised saturating counter with inc/clr/sat_o); all other logic SHALL be flat.

Verification
REQ-031 imem-only read: imem_req_i = 1 at 0x100, bus_gnt_i = 1 at cycle 0, rvalid at cycle 2 with rdata 0xDEADBEEF -> imem_gnt_o high at cycle 0, imem_rvalid_o/rdata at cycle 2, imem_stall_o high for cycles 0-1.
REQ-032 Simultaneous requests, gnt always 1, rvalid 1 cycle after grant -> dmem granted first with bus_we_o/be/wdata passed through; imem granted on the next IDLE.
REQ-033 Starvation, STARVE_LIMIT = 2, both requests held high -> grant order dmem, dmem, imem, dmem, dmem, imem.
REQ-034 Spurious bus_rvalid_i in IDLE, and bus_gnt_i = 0 for 5 cycles -> no rvalid_o, no state change, and bus_req_o held with stable address for all 5 cycles.
REQ-035 rst_ni low mid-WAIT (dmem owner), rvalid arriving 1 cycle after release -> no dmem_rvalid_o; next request arbitrates normally from IDLE.
